// File: rtl/spi_flash_slave.sv
// SPI flash-style read slave. Serves a single read opcode followed by a
// 24-bit byte address, then streams 32-bit words from a backing store
// MSB first for as long as the master keeps the slave selected. Words are
// prefetched one ahead so the next word is normally ready when it is needed.
module spi_flash_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] READ_CMD    = 8'h03
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] IGNORE = 3'd4;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   ss_d;
  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   ss_rise;
  logic                   ss_fall;

  logic [2:0]  state;
  logic [4:0]  bit_cnt;
  logic [22:0] rx_shift;
  logic [31:0] tx_shift;
  logic [23:0] fetch_addr;
  logic [31:0] hold_data;
  logic        hold_valid;
  logic        pend_valid;
  logic [23:0] pend_addr;
  logic        req_drop;

  logic [7:0]  cmd_byte;
  logic [23:0] addr_word;
  logic        addr_done;
  logic        load_now;
  logic        new_req;
  logic [23:0] new_addr;
  logic        ack_take;

  // The ss chain resets low so a slave select held low across reset never
  // looks like a falling edge; only a fresh high-to-low select starts a read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sck_sync[0]  <= spi_sck;
      ss_sync[0]   <= spi_ss;
      mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;

  assign cmd_byte  = {rx_shift[6:0], mosi_s};
  assign addr_word = {rx_shift, mosi_s};
  assign addr_done = (state == ADDR) && sck_rise && (bit_cnt == 5'd23) && !ss_rise;
  assign load_now  = (state == DATA) && sck_fall && (bit_cnt == 5'd0) && !ss_rise;
  assign new_req   = addr_done | load_now;
  assign new_addr  = addr_done ? addr_word : fetch_addr + 24'd4;
  // Late data for a word already replaced by zeros is never accepted.
  assign ack_take  = mem_req && mem_ack && !req_drop && !ss_rise &&
                     (state == DATA) && !(load_now && !hold_valid);

  assign busy = (state != IDLE) && !ss_s;

  // Protocol FSM: command/address capture on sck rise, data shift-out on sck fall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      fetch_addr <= '0;
      spi_miso   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ss_fall) begin
        overrun <= 1'b0;
      end
      if (ss_rise) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            spi_miso <= 1'b0;
            if (ss_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[21:0], mosi_s};
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                state   <= (cmd_byte == READ_CMD) ? ADDR : IGNORE;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[21:0], mosi_s};
              if (addr_done) begin
                bit_cnt    <= '0;
                fetch_addr <= addr_word;
                state      <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          DATA: begin
            if (sck_fall) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd0) begin
                fetch_addr <= fetch_addr + 24'd4;
                if (hold_valid) begin
                  spi_miso <= hold_data[31];
                  tx_shift <= {hold_data[30:0], 1'b0};
                end else begin
                  spi_miso <= 1'b0;
                  tx_shift <= '0;
                  overrun  <= 1'b1;
                end
              end else begin
                spi_miso <= tx_shift[31];
                tx_shift <= {tx_shift[30:0], 1'b0};
              end
            end
          end
          IGNORE: begin
            spi_miso <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            spi_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register: filled by an accepted read, emptied when a word is loaded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (ss_rise) begin
      hold_valid <= 1'b0;
    end else if (ack_take) begin
      hold_data  <= mem_rdata;
      hold_valid <= 1'b1;
    end else if (load_now) begin
      hold_valid <= 1'b0;
    end
  end

  // Memory request port: one outstanding read plus one queued address, so a
  // new request waits for any earlier handshake (even an abandoned one).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      req_drop   <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end
      if (ss_rise) begin
        pend_valid <= 1'b0;
        if (mem_req) begin
          req_drop <= 1'b1;
        end
      end else begin
        if (load_now && !hold_valid) begin
          pend_valid <= 1'b0;
          if (mem_req) begin
            req_drop <= 1'b1;
          end
        end
        if (new_req) begin
          if (mem_req) begin
            pend_valid <= 1'b1;
            pend_addr  <= new_addr;
          end else begin
            mem_req    <= 1'b1;
            mem_addr   <= new_addr;
            req_drop   <= 1'b0;
            pend_valid <= 1'b0;
          end
        end else if (pend_valid && !mem_req) begin
          mem_req    <= 1'b1;
          mem_addr   <= pend_addr;
          req_drop   <= 1'b0;
          pend_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed self-checking bench for spi_flash_slave: drives an SPI mode 0
// master with a slow sck and models a backing store with configurable
// acknowledge latency.
module tb_spi_flash_slave;

  localparam int HALF_NS = 80;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        overrun;

  int          check_count = 0;
  int          error_count = 0;
  logic [23:0] req_log[$];
  logic        slow_next;
  logic        miso_or;
  logic [31:0] word_a;
  logic [31:0] word_b;
  int          resp_cnt;
  int          resp_lat;
  logic        resp_active;

  // 100 MHz system clock.
  always #5 clock = ~clock;

  spi_flash_slave #(.SYNC_STAGES(2), .READ_CMD(8'h03)) dut (
    .clock     (clock),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_ss    (spi_ss),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  function automatic logic [31:0] memData(input logic [23:0] a);
    case (a)
      24'h000100: memData = 32'hDEADBEEF;
      24'hFFFFFC: memData = 32'hCAFEF00D;
      24'h000000: memData = 32'h12345678;
      default:    memData = {a, 8'h5A};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      #(HALF_NS);
      miso_or = miso_or | spi_miso;
      spi_sck = 1'b1;
      #(HALF_NS);
      spi_sck = 1'b0;
    end
  endtask

  task automatic readWord(output logic [31:0] w);
    w = '0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #(HALF_NS);
      w = {w[30:0], spi_miso};
      spi_sck = 1'b1;
      #(HALF_NS);
      spi_sck = 1'b0;
    end
  endtask

  task automatic startTransaction();
    miso_or = 1'b0;
    req_log.delete();
    spi_ss = 1'b0;
    #(HALF_NS);
  endtask

  task automatic endTransaction();
    #(HALF_NS);
    spi_ss = 1'b1;
    #(2 * HALF_NS);
  endtask

  // Backing-store model: acknowledges each request after a set latency.
  initial begin
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    resp_cnt    = 0;
    resp_lat    = 2;
    resp_active = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        mem_ack     = 1'b0;
        resp_cnt    = 0;
        resp_active = 1'b0;
        slow_next   = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt    = 0;
          resp_lat    = slow_next ? 40 : 2;
          slow_next   = 1'b0;
          req_log.push_back(mem_addr);
        end
        resp_cnt++;
        if (resp_cnt >= resp_lat) begin
          mem_ack     = 1'b1;
          mem_rdata   = memData(mem_addr);
          resp_active = 1'b0;
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    reset     = 1'b0;
    spi_ss    = 1'b1;
    spi_sck   = 1'b0;
    spi_mosi  = 1'b0;
    slow_next = 1'b0;
    miso_or   = 1'b0;
    @(posedge clock);
    #1;
    waitClocks(3);
    checkOutput("rst_miso", spi_miso, 0);
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovr", overrun, 0);
    reset = 1'b1;
    waitClocks(5);

    $display("[TB] single word read at 000100");
    startTransaction();
    applyStimulus(32'h03, 8);
    applyStimulus(32'h000100, 24);
    checkOutput("t1_busy", busy, 1);
    readWord(word_a);
    endTransaction();
    checkOutput("t1_cmd_miso", miso_or, 0);
    checkOutput("t1_word", word_a, 32'hDEADBEEF);
    checkOutput("t1_addr0", req_log.size() > 0 ? req_log[0] : 24'hBAD000, 24'h000100);
    checkOutput("t1_ovr", overrun, 0);
    checkOutput("t1_idle_miso", spi_miso, 0);

    $display("[TB] two words across the address wrap");
    startTransaction();
    applyStimulus(32'h03, 8);
    applyStimulus(32'hFFFFFC, 24);
    readWord(word_a);
    readWord(word_b);
    endTransaction();
    checkOutput("t2_word0", word_a, 32'hCAFEF00D);
    checkOutput("t2_word1", word_b, 32'h12345678);
    checkOutput("t2_nreq", req_log.size() >= 2, 1);
    checkOutput("t2_addr0", req_log.size() > 0 ? req_log[0] : 24'hBAD000, 24'hFFFFFC);
    checkOutput("t2_addr1", req_log.size() > 1 ? req_log[1] : 24'hBAD000, 24'h000000);
    checkOutput("t2_ovr", overrun, 0);

    $display("[TB] unsupported opcode 0B");
    startTransaction();
    applyStimulus(32'h0B, 8);
    applyStimulus(32'h123456, 24);
    applyStimulus(32'hFFFFFFFF, 32);
    checkOutput("t3_busy", busy, 1);
    endTransaction();
    checkOutput("t3_miso", miso_or, 0);
    checkOutput("t3_nreq", req_log.size(), 0);
    checkOutput("t3_busy_after", busy, 0);

    $display("[TB] late first word");
    startTransaction();
    slow_next = 1'b1;
    applyStimulus(32'h03, 8);
    applyStimulus(32'h000100, 24);
    readWord(word_a);
    readWord(word_b);
    checkOutput("t4_ovr_sel", overrun, 1);
    endTransaction();
    checkOutput("t4_word0", word_a, 32'h00000000);
    checkOutput("t4_word1", word_b, 32'h0001045A);
    checkOutput("t4_ovr_desel", overrun, 1);
    startTransaction();
    waitClocks(4);
    checkOutput("t4_ovr_clear", overrun, 0);
    endTransaction();

    $display("[TB] aborted address then fresh read");
    startTransaction();
    applyStimulus(32'h03, 8);
    applyStimulus(32'h000, 12);
    endTransaction();
    waitClocks(10);
    checkOutput("t5_nreq", req_log.size(), 0);
    checkOutput("t5_req_low", mem_req, 0);
    startTransaction();
    applyStimulus(32'h03, 8);
    applyStimulus(32'h000100, 24);
    readWord(word_a);
    endTransaction();
    checkOutput("t5_word", word_a, 32'hDEADBEEF);
    checkOutput("t5_addr0", req_log.size() > 0 ? req_log[0] : 24'hBAD000, 24'h000100);

    $display("[TB] reset during data phase");
    startTransaction();
    applyStimulus(32'h03, 8);
    applyStimulus(32'h000100, 24);
    slow_next = 1'b1;
    waitClocks(6);
    checkOutput("t6_pre_miso", spi_miso, 1);
    checkOutput("t6_pre_req", mem_req, 1);
    checkOutput("t6_pre_addr", mem_addr, 24'h000104);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_miso", spi_miso, 0);
    checkOutput("t6_rst_req", mem_req, 0);
    checkOutput("t6_rst_addr", mem_addr, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_ovr", overrun, 0);
    spi_ss  = 1'b1;
    spi_sck = 1'b0;
    waitClocks(3);
    reset = 1'b1;
    waitClocks(5);
    startTransaction();
    applyStimulus(32'h03, 8);
    applyStimulus(32'h000100, 24);
    readWord(word_a);
    endTransaction();
    checkOutput("t6_word", word_a, 32'hDEADBEEF);
    checkOutput("t6_addr0", req_log.size() > 0 ? req_log[0] : 24'hBAD000, 24'h000100);
    checkOutput("t6_ovr", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
